// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - rx_state_e   : deframer FSM states
//   - PARITY_EVEN / PARITY_ODD : values for the parity_type input
//   - DEFAULT_CLKS_PER_BIT     : 100 MHz system clock / 115200 baud
//   - UART_DATA_W              : data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    WAIT_IDLE
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned UART_DATA_W          = 8;

endpackage

// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if: serial input, frame configuration and received-byte
// status bundle of the UART receive front-end.
//   rx, parity_en, parity_type             : line and config, into the deframer
//   rx_data, rx_parity, rx_valid,
//   parity_err, frame_err, busy            : frame result, out of the deframer
// Modports: master = line/config driver and result consumer,
//           slave  = the deframer itself.
interface uart_rx_deframer_if;
  import uart_pkg::*;

  logic                   rx;
  logic                   parity_en;
  logic                   parity_type;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_parity;
  logic                   rx_valid;
  logic                   parity_err;
  logic                   frame_err;
  logic                   busy;

  modport master (
    output rx, parity_en, parity_type,
    input  rx_data, rx_parity, rx_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  rx, parity_en, parity_type,
    output rx_data, rx_parity, rx_valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/uart_rx_deframer_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser for an asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset; both flops load RESET_VAL
//   d_i    : asynchronous input
//   q_o    : synchronised output (two clocks of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive front-end. Synchronises rx, qualifies the
// start bit at mid-bit, samples 8 data bits LSB-first, an optional parity bit
// and the stop bit, then presents the byte and status with a one-cycle
// rx_valid pulse.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of uart_rx_deframer_if
//           in : rx (idle high), parity_en, parity_type (0 even, 1 odd)
//           out: rx_data, rx_parity, rx_valid, parity_err, frame_err, busy
// rx_data/rx_parity/parity_err/frame_err hold until the next rx_valid.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_rx_deframer_if.slave   bus
);

  localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF    = CLKS_PER_BIT / 2;

  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF - 1);
  localparam logic [2:0]         IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e              state_q,   state_d;
  logic [TIMER_W-1:0]     timer_q,   timer_d;
  logic [2:0]             idx_q,     idx_d;
  logic [DATA_BITS-1:0]   shift_q,   shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   pen_q,     pen_d;
  logic                   ptype_q,   ptype_d;
  logic [DATA_BITS-1:0]   data_q,    data_d;
  logic                   rpar_q,    rpar_d;
  logic                   perr_q,    perr_d;
  logic                   ferr_q,    ferr_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (bus.rx),
    .q_o    (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      pen_q     <= 1'b0;
      ptype_q   <= 1'b0;
      data_q    <= '0;
      rpar_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      pen_q     <= pen_d;
      ptype_q   <= ptype_d;
      data_q    <= data_d;
      rpar_q    <= rpar_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next state. The timer is zeroed on every transition so each state
  // measures its own interval from entry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    pen_d     = pen_q;
    ptype_d   = ptype_q;
    data_d    = data_q;
    rpar_d    = rpar_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (rx_s) begin
            state_d = IDLE;             // glitch, not a real start bit
          end else begin
            state_d   = DATA;
            idx_d     = '0;
            pen_d     = bus.parity_en;  // frame format frozen for this frame
            ptype_d   = bus.parity_type;
            par_bit_d = 1'b0;
          end
        end
      end

      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end
      end

      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = DONE;
          // Result registers load here so they are already valid in DONE.
          data_d  = shift_q;
          rpar_d  = par_bit_q;
          perr_d  = pen_q & (par_bit_q ^ (^shift_q) ^ ptype_q);
          ferr_d  = ~rx_s;
        end
      end

      DONE: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end

      WAIT_IDLE: begin
        timer_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.rx_valid   = (state_q == DONE);
    bus.rx_data    = data_q;
    bus.rx_parity  = rpar_q;
    bus.parity_err = perr_q;
    bus.frame_err  = ferr_q;
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer with CLKS_PER_BIT=16.
// Frames are described at the bit level (byte, parity bit, stop bit); a queue
// of expected results is computed from the framing rules and compared against
// every rx_valid pulse, including the pin-to-valid latency.
module tb_uart_rx_deframer;
  import uart_pkg::*;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_deframer_if u_if ();

  uart_rx_deframer #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       perr;
    logic       ferr;
    int         fall;
    int         pen;
  } exp_t;

  exp_t exp_q[$];
  int   valid_cyc[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result monitor.
  exp_t e;
  logic prev_valid = 1'b0;
  int   lat;
  int   t_exp;
  always @(negedge clk) begin
    if (u_if.rx_valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      check_eq("valid_single_cycle", prev_valid, 1'b0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid_queue", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("rx_data",    u_if.rx_data,    e.data);
        check_eq("rx_parity",  u_if.rx_parity,  e.par);
        check_eq("parity_err", u_if.parity_err, e.perr);
        check_eq("frame_err",  u_if.frame_err,  e.ferr);
        lat   = cyc - e.fall;
        t_exp = 2 + HALF + (9 + e.pen) * CPB + 1;
        if (lat + 1 >= t_exp && lat <= t_exp + 1)
          check_eq("latency", lat, lat);
        else
          check_eq("latency", lat, t_exp);
      end
    end
    prev_valid = u_if.rx_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_clks(input int n);
    u_if.rx = 1'b1;
    wait_clks(n);
  endtask

  // Drives one frame starting at a negedge. Config is changed mid-frame to
  // confirm the deframer uses the values present at the start bit.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                            input logic pbit, input logic stop, input logic track);
    exp_t x;
    u_if.parity_en   = pen;
    u_if.parity_type = ptype;
    if (track) begin
      x.data = d;
      x.par  = pen ? pbit : 1'b0;
      x.perr = pen ? (pbit != ((^d) ^ ptype)) : 1'b0;
      x.ferr = !stop;
      x.fall = cyc;
      x.pen  = pen ? 1 : 0;
      exp_q.push_back(x);
    end
    u_if.rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      if (i == 3) begin
        u_if.parity_en   = 1'($urandom);
        u_if.parity_type = 1'($urandom);
      end
      wait_clks(CPB);
    end
    if (pen) begin
      u_if.rx = pbit;
      wait_clks(CPB);
    end
    u_if.rx = stop;
    wait_clks(CPB);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int          nv;
  int          k;
  logic        busy_dropped;
  logic [7:0]  d;
  logic [7:0]  d3c;
  logic        pen, ptype, pbit, stop;

  initial begin
    u_if.rx          = 1'b1;
    u_if.parity_en   = 1'b0;
    u_if.parity_type = PARITY_EVEN;
    wait_clks(3);

    // Outputs while held in reset.
    check_eq("rst_rx_data",    u_if.rx_data,    8'h00);
    check_eq("rst_rx_valid",   u_if.rx_valid,   1'b0);
    check_eq("rst_busy",       u_if.busy,       1'b0);
    check_eq("rst_parity_err", u_if.parity_err, 1'b0);
    check_eq("rst_frame_err",  u_if.frame_err,  1'b0);
    check_eq("rst_rx_parity",  u_if.rx_parity,  1'b0);
    rst_n = 1'b1;
    idle_clks(2 * CPB);

    // Reset mid-frame abandons 0x3C.
    d3c = 8'h3C;
    nv  = valid_cyc.size();
    u_if.rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      u_if.rx = d3c[i];
      wait_clks(CPB);
    end
    u_if.rx = d3c[3];
    wait_clks(HALF);
    check_eq("midframe_busy_before_rst", u_if.busy, 1'b1);
    rst_n = 1'b0;
    u_if.rx = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(1);
    check_eq("post_rst_busy",       u_if.busy,       1'b0);
    check_eq("post_rst_rx_data",    u_if.rx_data,    8'h00);
    check_eq("post_rst_frame_err",  u_if.frame_err,  1'b0);
    check_eq("post_rst_parity_err", u_if.parity_err, 1'b0);
    idle_clks(20 * CPB);
    check_eq("midframe_no_valid", valid_cyc.size(), nv);
    send_frame(8'h3C, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b1);
    idle_clks(2 * CPB);

    // Even parity, correct.
    send_frame(8'hA5, 1'b1, PARITY_EVEN, 1'b0, 1'b1, 1'b1);
    idle_clks(2 * CPB);

    // Odd parity: wrong then correct.
    send_frame(8'hA5, 1'b1, PARITY_ODD, 1'b0, 1'b1, 1'b1);
    idle_clks(2 * CPB);
    send_frame(8'h07, 1'b1, PARITY_ODD, 1'b0, 1'b1, 1'b1);
    idle_clks(2 * CPB);

    // Back-to-back, no parity.
    nv = valid_cyc.size();
    send_frame(8'h00, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b1);
    idle_clks(2 * CPB);
    check_eq("b2b_count", valid_cyc.size() - nv, 2);
    if (valid_cyc.size() >= nv + 2)
      check_eq("b2b_spacing", valid_cyc[nv+1] - valid_cyc[nv], 10 * CPB);

    // Framing error followed by a 40 bit-time break.
    nv = valid_cyc.size();
    send_frame(8'h55, 1'b0, PARITY_EVEN, 1'b0, 1'b0, 1'b1);
    busy_dropped = 1'b0;
    for (int i = 0; i < 40 * CPB; i++) begin
      @(negedge clk);
      if (u_if.busy !== 1'b1) busy_dropped = 1'b1;
    end
    check_eq("break_busy_held", busy_dropped, 1'b0);
    check_eq("break_single_valid", valid_cyc.size() - nv, 1);
    u_if.rx = 1'b1;
    wait_clks(5);
    check_eq("break_busy_released", u_if.busy, 1'b0);
    check_eq("break_frame_err_held", u_if.frame_err, 1'b1);
    idle_clks(3 * CPB);
    check_eq("break_no_extra_valid", valid_cyc.size() - nv, 1);

    // Glitch rejection.
    nv = valid_cyc.size();
    u_if.rx = 1'b0;
    wait_clks(4);
    u_if.rx = 1'b1;
    k = 0;
    while (u_if.busy !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq("glitch_busy_rose", u_if.busy, 1'b1);
    k = 0;
    while (u_if.busy !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("glitch_back_idle_in_time", (k <= HALF + 3), 1'b1);
    idle_clks(12 * CPB);
    check_eq("glitch_no_valid", valid_cyc.size(), nv);

    // Randomised frames.
    for (int n = 0; n < 16; n++) begin
      d     = 8'($urandom);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      pbit  = 1'($urandom);
      stop  = ($urandom_range(0, 7) != 0);
      send_frame(d, pen, ptype, pbit, stop, 1'b1);
      if (!stop)
        idle_clks(CPB + $urandom_range(0, CPB));
      else
        idle_clks($urandom_range(0, 2 * CPB));
    end
    idle_clks(3 * CPB);

    check_eq("all_frames_seen", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive front-end of the 8-bit UART. Synchronises the serial `rx` line, detects and qualifies the start bit, and samples 8 data bits LSB-first at mid-bit.
- Samples an optional parity bit and the stop bit, then presents the byte with parity and framing status as a single-cycle valid pulse.
- Sits directly upstream of the parity-check and receive-buffer logic. It supplies the byte and the received parity bit they consume.

Parameters:
- CLKS_PER_BIT, 868, system clocks per bit period (100 MHz / 115200). Must be ≥ 4.
- DATA_BITS, 8, data bits per frame. Fixed at 8 for this design; present for readability only.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  raw serial line, asynchronous to clk, idle high.
- parity_en  input  1  1 = frame carries a parity bit after the data.
- parity_type  input  1  0 = even, 1 = odd.
- rx_data  output  8  received byte, LSB = first data bit.
- rx_parity  output  1  received parity bit; 0 when parity_en was 0.
- rx_valid  output  1  one-cycle pulse: frame complete, all status outputs valid.
- parity_err  output  1  received parity ≠ expected; 0 when parity disabled.
- frame_err  output  1  stop bit sampled low.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; state = IDLE.
  - Both synchroniser flops reset to 1, which is idle-high.
  - Counters are cleared.
  - Reset mid-frame abandons the frame and does not emit rx_valid.
- Synchroniser: 2-FF on rx → rx_s. The FSM uses only rx_s.
- Bit timer: counts 0..CLKS_PER_BIT-1 and is reloaded on every state entry. Bit index counts 0..7.
- State IDLE: busy=0. When rx_s=0 → START, timer cleared.
- State START: wait CLKS_PER_BIT/2 cycles (integer division), then sample rx_s.
  - rx_s=1: false start (glitch) → IDLE, no output.
  - rx_s=0: go to DATA. Latch parity_en and parity_type here; changes mid-frame are ignored.
- State DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first.
  - After bit index 7: go to PARITY if the latched parity_en=1, else STOP.
- State PARITY: after CLKS_PER_BIT cycles, sample rx_s into rx_parity.
  - Expected parity = (XOR of the 8 data bits) XOR parity_type.
  - parity_err = received ≠ expected.
- State STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - frame_err = ~rx_s.
  - Next state DONE.
- State DONE: one cycle.
  - rx_valid=1; rx_data, rx_parity, parity_err and frame_err update in this cycle.
  - Then IDLE if rx_s=1. If rx_s=0 (break or framing fault), go to WAIT_IDLE.
- State WAIT_IDLE: hold until rx_s=1, then IDLE. This prevents a break condition from re-triggering as a start bit.
- Output timing:
  - rx_data, rx_parity and the error flags hold their values until the next rx_valid.
  - rx_valid is high for exactly one clock per accepted frame.
- Latency: rx_valid asserts T cycles after rx falls at the pin, where T = 2 + CLKS_PER_BIT/2 + (9 + parity_en)·CLKS_PER_BIT + 1, with ±1 cycle of synchroniser uncertainty.
- A frame with both a parity error and a framing error asserts both flags together.
- A start edge that arrives in the cycle DONE → IDLE is caught on the next IDLE cycle. The maximum added skew is 1 clock, which is acceptable.

Decomposition:
- Shared package `uart_pkg` holds:
  - the FSM state enum: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE;
  - PARITY_EVEN=0 and PARITY_ODD=1 constants;
  - default CLKS_PER_BIT.
- One sub-module: `sync_2ff` (1-bit two-flop synchroniser, async active-low reset to a parameterised value). It is reused later for the TX CTS input.

Test Plan (all with CLKS_PER_BIT=16):
- Reset mid-frame: start sending 0x3C, assert rst_n=0 during bit 3, release and idle → no rx_valid. After reset: all outputs 0, busy=0. Then send 0x3C cleanly → rx_data=0x3C.
- Even parity OK: parity_en=1, parity_type=0, send 0xA5 with parity bit 0 and stop=1 → one rx_valid pulse; rx_data=0xA5, rx_parity=0, parity_err=0, frame_err=0.
- Parity error: parity_en=1, parity_type=1, send 0xA5 with parity bit 0 → rx_valid, parity_err=1. Then send 0x07 with parity bit 0 (odd, correct) → parity_err=0.
- No parity, back-to-back: parity_en=0, send 0x00 then 0xFF with no idle gap → two rx_valid pulses, 10·16 cycles apart; rx_data=0x00 then 0xFF; rx_parity=0.
- Frame error / break: send 0x55 with stop=0, then hold rx low 40 bit-times → single rx_valid with frame_err=1, busy=1 until rx returns high. No further rx_valid until a new start bit arrives.
- Glitch rejection: rx low for 4 clocks then high → busy pulses briefly, no rx_valid, FSM back in IDLE within CLKS_PER_BIT/2+3 cycles.
